// File: rtl/in_buffer_rd_sched_if.sv
// rtl/in_buffer_rd_sched_if.sv - control, config and read-bus signals of the input-buffer read sequencer
interface in_buffer_rd_sched_if #(
    parameter int IMG_AW = 16,
    parameter int W_AW   = 16,
    parameter int B_AW   = 8
);
    logic              i_start;
    logic              i_img_ready;
    logic [IMG_AW-1:0] cfg_in_len;
    logic [B_AW-1:0]   cfg_out_num;
    logic [W_AW-1:0]   cfg_w_base;
    logic              i_stall;
    logic              o_rd_en;
    logic [IMG_AW-1:0] o_img_addr;
    logic [W_AW-1:0]   o_w_addr;
    logic [B_AW-1:0]   o_b_addr;
    logic              o_vld;
    logic              o_first;
    logic              o_last_k;
    logic              o_busy;
    logic              o_cfg_err;
    logic              o_last;
    logic              o_done;

    modport master (
        output i_start, i_img_ready, cfg_in_len, cfg_out_num, cfg_w_base, i_stall,
        input  o_rd_en, o_img_addr, o_w_addr, o_b_addr, o_vld, o_first, o_last_k,
        input  o_busy, o_cfg_err, o_last, o_done
    );

    modport slave (
        input  i_start, i_img_ready, cfg_in_len, cfg_out_num, cfg_w_base, i_stall,
        output o_rd_en, o_img_addr, o_w_addr, o_b_addr, o_vld, o_first, o_last_k,
        output o_busy, o_cfg_err, o_last, o_done
    );
endinterface

// File: rtl/in_buffer_rd_sched.sv
// rtl/in_buffer_rd_sched.sv - walks image/weight/bias buffers in fully-connected order, one read per cycle
module in_buffer_rd_sched #(
    parameter int IMG_AW = 16,
    parameter int W_AW   = 16,
    parameter int B_AW   = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    in_buffer_rd_sched_if.slave  bus
);
    localparam int DCW = $clog2(RD_LAT + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_IMG, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [IMG_AW-1:0] len_q, len_d, k_q, k_d, img_addr_q, img_addr_d;
    logic [B_AW-1:0]   num_q, num_d, n_q, n_d, b_addr_q, b_addr_d;
    logic [W_AW-1:0]   w_q, w_d, w_addr_q, w_addr_d;
    logic              cfg_err_q, cfg_err_d;
    logic              rd_en_q, rd_en_d, first_q, first_d, last_k_q, last_k_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic [RD_LAT-1:0] vld_sr_q, first_sr_q, last_k_sr_q;
    logic              k_end, n_end;

    assign k_end = (k_q == len_q - IMG_AW'(1));
    assign n_end = (n_q == num_q - B_AW'(1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        num_d      = num_q;
        k_d        = k_q;
        n_d        = n_q;
        w_d        = w_q;
        cfg_err_d  = cfg_err_q;
        drain_d    = drain_q;
        rd_en_d    = 1'b0;
        first_d    = 1'b0;
        last_k_d   = 1'b0;
        img_addr_d = img_addr_q;
        w_addr_d   = w_addr_q;
        b_addr_d   = b_addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    len_d     = bus.cfg_in_len;
                    num_d     = bus.cfg_out_num;
                    w_d       = bus.cfg_w_base;
                    k_d       = '0;
                    n_d       = '0;
                    cfg_err_d = 1'b0;
                    if (bus.cfg_in_len == '0 || bus.cfg_out_num == '0) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_WAIT_IMG;
                    end
                end
            end
            S_WAIT_IMG: begin
                if (bus.i_img_ready) state_d = S_RUN;
            end
            S_RUN: begin
                // Weight address is a running counter, equal to w_base + n*K + k.
                if (!bus.i_stall) begin
                    rd_en_d    = 1'b1;
                    img_addr_d = k_q;
                    w_addr_d   = w_q;
                    b_addr_d   = n_q;
                    first_d    = (k_q == '0);
                    last_k_d   = k_end;
                    w_d        = w_q + W_AW'(1);
                    if (k_end) begin
                        k_d = '0;
                        n_d = n_q + B_AW'(1);
                        if (n_end) begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end else begin
                        k_d = k_q + IMG_AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // One extra cycle so o_last follows the final o_vld rather than coinciding.
                if (drain_q == DRAIN_LAST) state_d = S_DONE;
                else                       drain_d = drain_q + DCW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            num_q      <= '0;
            k_q        <= '0;
            n_q        <= '0;
            w_q        <= '0;
            cfg_err_q  <= 1'b0;
            drain_q    <= '0;
            rd_en_q    <= 1'b0;
            first_q    <= 1'b0;
            last_k_q   <= 1'b0;
            img_addr_q <= '0;
            w_addr_q   <= '0;
            b_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            num_q      <= num_d;
            k_q        <= k_d;
            n_q        <= n_d;
            w_q        <= w_d;
            cfg_err_q  <= cfg_err_d;
            drain_q    <= drain_d;
            rd_en_q    <= rd_en_d;
            first_q    <= first_d;
            last_k_q   <= last_k_d;
            img_addr_q <= img_addr_d;
            w_addr_q   <= w_addr_d;
            b_addr_q   <= b_addr_d;
        end
    end

    // Tag pipeline matches BRAM latency and never stalls.
    if (RD_LAT == 1) begin : g_pipe1
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_sr_q    <= '0;
                first_sr_q  <= '0;
                last_k_sr_q <= '0;
            end else begin
                vld_sr_q    <= rd_en_q;
                first_sr_q  <= first_q;
                last_k_sr_q <= last_k_q;
            end
        end
    end else begin : g_pipen
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_sr_q    <= '0;
                first_sr_q  <= '0;
                last_k_sr_q <= '0;
            end else begin
                vld_sr_q    <= {vld_sr_q[RD_LAT-2:0], rd_en_q};
                first_sr_q  <= {first_sr_q[RD_LAT-2:0], first_q};
                last_k_sr_q <= {last_k_sr_q[RD_LAT-2:0], last_k_q};
            end
        end
    end

    assign bus.o_rd_en    = rd_en_q;
    assign bus.o_img_addr = img_addr_q;
    assign bus.o_w_addr   = w_addr_q;
    assign bus.o_b_addr   = b_addr_q;
    assign bus.o_vld      = vld_sr_q[RD_LAT-1];
    assign bus.o_first    = first_sr_q[RD_LAT-1];
    assign bus.o_last_k   = last_k_sr_q[RD_LAT-1];
    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_cfg_err  = cfg_err_q;
    assign bus.o_last     = (state_q == S_DONE);
    assign bus.o_done     = (state_q == S_DONE);
endmodule

// File: tb/tb_in_buffer_rd_sched.sv
// tb/tb_in_buffer_rd_sched.sv - scoreboard bench; RD_LAT=1 and RD_LAT=2 instances driven in lockstep
module tb_in_buffer_rd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    in_buffer_rd_sched_if #(.IMG_AW(16), .W_AW(16), .B_AW(8)) bus1();
    in_buffer_rd_sched_if #(.IMG_AW(16), .W_AW(16), .B_AW(8)) bus2();

    in_buffer_rd_sched #(.IMG_AW(16), .W_AW(16), .B_AW(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    in_buffer_rd_sched #(.IMG_AW(16), .W_AW(16), .B_AW(8), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    assign bus2.i_start     = bus1.i_start;
    assign bus2.i_img_ready = bus1.i_img_ready;
    assign bus2.cfg_in_len  = bus1.cfg_in_len;
    assign bus2.cfg_out_num = bus1.cfg_out_num;
    assign bus2.cfg_w_base  = bus1.cfg_w_base;
    assign bus2.i_stall     = bus1.i_stall;

    logic        rd[2], vld[2], fst[2], lk[2], lst[2], dn[2], busy[2], cerr[2];
    logic [15:0] img[2], wad[2];
    logic [7:0]  bad[2];
    assign rd[0] = bus1.o_rd_en;    assign rd[1] = bus2.o_rd_en;
    assign vld[0] = bus1.o_vld;     assign vld[1] = bus2.o_vld;
    assign fst[0] = bus1.o_first;   assign fst[1] = bus2.o_first;
    assign lk[0] = bus1.o_last_k;   assign lk[1] = bus2.o_last_k;
    assign lst[0] = bus1.o_last;    assign lst[1] = bus2.o_last;
    assign dn[0] = bus1.o_done;     assign dn[1] = bus2.o_done;
    assign busy[0] = bus1.o_busy;   assign busy[1] = bus2.o_busy;
    assign cerr[0] = bus1.o_cfg_err; assign cerr[1] = bus2.o_cfg_err;
    assign img[0] = bus1.o_img_addr; assign img[1] = bus2.o_img_addr;
    assign wad[0] = bus1.o_w_addr;  assign wad[1] = bus2.o_w_addr;
    assign bad[0] = bus1.o_b_addr;  assign bad[1] = bus2.o_b_addr;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected issue entry: {img[15:0], w[15:0], b[7:0], first, last_k}
    logic [41:0] eq0[$], eq1[$];
    logic [1:0]  tq0[$], tq1[$];
    int          issue_cnt[2] = '{0, 0};
    int          last_cnt[2]  = '{0, 0};
    logic [3:0]  hist[2]      = '{4'b0, 4'b0};

    always @(negedge clk) begin
        logic [41:0] e;
        logic [1:0]  t;
        int          nq;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                if (d == 0) begin eq0.delete(); tq0.delete(); end
                else        begin eq1.delete(); tq1.delete(); end
                hist[d] = 4'b0;
            end else begin
                chk($sformatf("vld_latency%0d", d), vld[d], hist[d][d]);
                hist[d] = {hist[d][2:0], rd[d]};
                chk($sformatf("done_eq_last%0d", d), dn[d], lst[d]);
                if (rd[d]) begin
                    issue_cnt[d]++;
                    nq = (d == 0) ? eq0.size() : eq1.size();
                    chk($sformatf("issue_expected%0d", d), nq != 0, 1);
                    if (nq != 0) begin
                        if (d == 0) e = eq0.pop_front();
                        else        e = eq1.pop_front();
                        chk($sformatf("img_addr%0d", d), img[d], e[41:26]);
                        chk($sformatf("w_addr%0d", d), wad[d], e[25:10]);
                        chk($sformatf("b_addr%0d", d), bad[d], e[9:2]);
                        if (d == 0) tq0.push_back(e[1:0]);
                        else        tq1.push_back(e[1:0]);
                    end
                end
                if (vld[d]) begin
                    nq = (d == 0) ? tq0.size() : tq1.size();
                    chk($sformatf("vld_expected%0d", d), nq != 0, 1);
                    if (nq != 0) begin
                        if (d == 0) t = tq0.pop_front();
                        else        t = tq1.pop_front();
                        chk($sformatf("first%0d", d), fst[d], t[1]);
                        chk($sformatf("last_k%0d", d), lk[d], t[0]);
                    end
                end
                if (lst[d]) begin
                    last_cnt[d]++;
                    chk($sformatf("last_after_vld%0d", d), (d == 0) ? tq0.size() : tq1.size(), 0);
                    chk($sformatf("last_after_issue%0d", d), (d == 0) ? eq0.size() : eq1.size(), 0);
                end
            end
        end
    end

    task automatic push_exp(input int kk, input int nn, input int wb);
        logic [41:0] e;
        logic [15:0] ia, wa;
        logic [7:0]  ba;
        for (int n = 0; n < nn; n++) begin
            for (int k = 0; k < kk; k++) begin
                ia = 16'(k);
                wa = 16'(wb + n * kk + k);
                ba = 8'(n);
                e  = {ia, wa, ba, (k == 0), (k == kk - 1)};
                eq0.push_back(e);
                eq1.push_back(e);
            end
        end
    endtask

    task automatic start(input int kk, input int nn, input int wb);
        bus1.cfg_in_len  = 16'(kk);
        bus1.cfg_out_num = 8'(nn);
        bus1.cfg_w_base  = 16'(wb);
        bus1.i_start     = 1'b1;
        @(posedge clk); #1;
        bus1.i_start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (!busy[0] && !busy[1]) return;
        end
        chk("idle_timeout", busy[0] | busy[1], 0);
    endtask

    task automatic wait_issues(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (issue_cnt[0] >= target) return;
        end
        chk("issue_timeout", issue_cnt[0], target);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_outs%0d", tag, d),
                {rd[d], vld[d], fst[d], lk[d], lst[d], dn[d], busy[d], cerr[d]}, 0);
            chk($sformatf("%s_addr%0d", tag, d), {img[d], wad[d], bad[d]}, 0);
        end
    endtask

    int ib, lb;

    initial begin
        bus1.i_start = 1'b0; bus1.i_img_ready = 1'b0; bus1.i_stall = 1'b0;
        bus1.cfg_in_len = '0; bus1.cfg_out_num = '0; bus1.cfg_w_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_zero("reset");
        rst = 1'b0;

        // T1: basic walk; cfg change after start must be ignored
        bus1.i_img_ready = 1'b1;
        ib = issue_cnt[0]; lb = last_cnt[0];
        push_exp(3, 2, 10);
        start(3, 2, 10);
        bus1.cfg_in_len = 16'd7; bus1.cfg_w_base = 16'd99;
        wait_idle(60);
        chk("t1_issues0", issue_cnt[0] - ib, 6);
        chk("t1_issues1", issue_cnt[1] - ib, 6);
        chk("t1_last0", last_cnt[0] - lb, 1);
        chk("t1_last1", last_cnt[1] - lb, 1);

        // T2: stall after the 2nd issue holds outputs
        ib = issue_cnt[0];
        push_exp(3, 2, 10);
        start(3, 2, 10);
        wait_issues(ib + 2, 60);
        bus1.i_stall = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("t2_stall_rd%0d", d), rd[d], 0);
                chk($sformatf("t2_stall_img%0d", d), img[d], 1);
                chk($sformatf("t2_stall_w%0d", d), wad[d], 11);
            end
        end
        bus1.i_stall = 1'b0;
        wait_idle(60);
        chk("t2_issues0", issue_cnt[0] - ib, 6);
        chk("t2_issues1", issue_cnt[1] - ib, 6);

        // T3: image not ready for 5 cycles
        bus1.i_img_ready = 1'b0;
        ib = issue_cnt[0];
        push_exp(3, 2, 10);
        start(3, 2, 10);
        repeat (5) begin
            @(negedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("t3_busy%0d", d), busy[d], 1);
                chk($sformatf("t3_no_rd%0d", d), rd[d], 0);
            end
        end
        bus1.i_img_ready = 1'b1;
        wait_idle(60);
        chk("t3_issues0", issue_cnt[0] - ib, 6);

        // T4: K=0 is a config error, no reads, immediate done
        ib = issue_cnt[0]; lb = last_cnt[0];
        start(0, 4, 0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t4_err%0d", d), cerr[d], 1);
            chk($sformatf("t4_done%0d", d), dn[d], 1);
        end
        wait_idle(10);
        chk("t4_no_issue", issue_cnt[0] - ib, 0);
        chk("t4_last", last_cnt[0] - lb, 1);
        chk("t4_err_sticky", cerr[0], 1);
        push_exp(1, 1, 5);
        start(1, 1, 5);
        chk("t4_err_clr0", cerr[0], 0);
        chk("t4_err_clr1", cerr[1], 0);
        wait_idle(30);
        chk("t4_single_issue", issue_cnt[0] - ib, 1);

        // T5: reset during RUN at issue 3
        ib = issue_cnt[0]; lb = last_cnt[1];
        push_exp(3, 2, 20);
        start(3, 2, 20);
        wait_issues(ib + 3, 60);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("t5_rst");
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("t5_no_last", last_cnt[1] - lb, 0);
        ib = issue_cnt[0];
        push_exp(3, 2, 20);
        start(3, 2, 20);
        wait_idle(60);
        chk("t5_rerun_issues", issue_cnt[0] - ib, 6);
        chk("t5_rerun_last", last_cnt[1] - lb, 1);

        // T6: start pulse during RUN is ignored
        ib = issue_cnt[0]; lb = last_cnt[1];
        push_exp(2, 3, 100);
        start(2, 3, 100);
        wait_issues(ib + 2, 60);
        bus1.cfg_in_len = 16'd5; bus1.cfg_w_base = 16'd300;
        bus1.i_start = 1'b1;
        @(posedge clk); #1;
        bus1.i_start = 1'b0;
        wait_idle(60);
        repeat (4) @(negedge clk);
        #1;
        chk("t6_issues0", issue_cnt[0] - ib, 6);
        chk("t6_issues1", issue_cnt[1] - ib, 6);
        chk("t6_last1", last_cnt[1] - lb, 1);
        chk("t6_idle", busy[0] | busy[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
